fifo_stream_drain: RTL and testbench

//  Downstream consumer of the 32-deep synchronous FIFO. Drains words via the FIFO read port
//  (one-cycle registered read latency) and presents them on a valid/ready stream with packet framing.

---
 rtl/fifo_stream_drain_if.sv | 36 +++
 rtl/fifo_stream_drain.sv | 101 ++++++++++
 tb/tb_fifo_stream_drain.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_drain_if.sv
// Stream-drain bundle: FIFO read port on one side, framed valid/ready stream on the other.
// master = drain block, slave = FIFO + stream sink environment.
interface fifo_stream_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty_f;
    logic                  fifo_read_enable;
    logic [DATA_WIDTH-1:0] fifo_data_output;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [15:0]           pkt_count;

    modport master (
        input  fifo_empty_f,
        input  fifo_data_output,
        input  m_ready,
        output fifo_read_enable,
        output m_valid,
        output m_data,
        output m_last,
        output pkt_count
    );

    modport slave (
        output fifo_empty_f,
        output fifo_data_output,
        output m_ready,
        input  fifo_read_enable,
        input  m_valid,
        input  m_data,
        input  m_last,
        input  pkt_count
    );
endinterface

// File: rtl/fifo_stream_drain.sv
// Drains a registered-read FIFO into a 2-entry skid buffer and presents it as a framed
// valid/ready stream; reads are credit-limited so the buffer can never overflow.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 8
) (
    input  logic                clk,
    input  logic                reset_signal,
    fifo_stream_drain_if.master bus
);
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            buf_count_q, buf_count_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [15:0]           pkt_count_q, pkt_count_d;

    logic       valid;
    logic       last;
    logic       pop;
    logic       capture;
    logic       rd_en;
    logic [2:0] credit_used;

    always_comb begin
        valid       = (buf_count_q != '0);
        last        = valid & (word_idx_q == LAST_IDX);
        pop         = valid & bus.m_ready;
        capture     = rd_pending_q;
        // Words held plus words in flight, minus the one leaving now, must stay below 2.
        credit_used = 3'(buf_count_q) + 3'(rd_pending_q) - 3'(pop);
        rd_en       = !reset_signal & !bus.fifo_empty_f & (credit_used < 3'd2);

        head_d       = head_q;
        tail_d       = tail_q;
        buf_count_d  = buf_count_q;
        rd_pending_d = rd_en;
        word_idx_d   = word_idx_q;
        pkt_count_d  = pkt_count_q;

        case ({capture, pop})
            2'b10: begin
                if (buf_count_q == 2'd0) head_d = bus.fifo_data_output;
                else                     tail_d = bus.fifo_data_output;
                buf_count_d = buf_count_q + 2'd1;
            end
            2'b01: begin
                head_d      = tail_q;
                buf_count_d = buf_count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous capture and pop: the queue shifts by one, count is unchanged.
                if (buf_count_q == 2'd1) begin
                    head_d = bus.fifo_data_output;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.fifo_data_output;
                end
            end
            default: ;
        endcase

        if (pop) begin
            word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + IDX_W'(1);
            if (last) pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_signal) begin
            head_q       <= '0;
            tail_q       <= '0;
            buf_count_q  <= '0;
            rd_pending_q <= 1'b0;
            word_idx_q   <= '0;
            pkt_count_q  <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            buf_count_q  <= buf_count_d;
            rd_pending_q <= rd_pending_d;
            word_idx_q   <= word_idx_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign bus.fifo_read_enable = rd_en;
    assign bus.m_valid          = valid;
    assign bus.m_data           = head_q;
    assign bus.m_last           = last;
    assign bus.pkt_count        = pkt_count_q;

    capture_never_overflows: assert property (@(posedge clk) disable iff (reset_signal)
        !(rd_pending_q && (buf_count_q == 2'd2) && !pop));

    never_reads_empty_fifo: assert property (@(posedge clk) disable iff (reset_signal)
        !(bus.fifo_read_enable && bus.fifo_empty_f));
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: queue-based FIFO model plus a stream reference model
// (words out == words in, framing from the accepted-word count), with directed and random traffic.
module tb_fifo_stream_drain;
    localparam int DW = 32;
    localparam int PL = 8;

    logic clk          = 1'b0;
    logic reset_signal = 1'b1;

    fifo_stream_drain_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk          (clk),
        .reset_signal (reset_signal),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // FIFO model (registered read data, flag updated at the edge) and stream reference model
    logic          fifo_empty_q = 1'b1;
    logic [DW-1:0] fifo_dout_q  = '0;
    logic          wr_en        = 1'b0;
    logic [DW-1:0] wr_data      = '0;
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_seen[$];
    int unsigned   pops       = 0;
    int            out_cnt    = 0;
    int            max_out    = 0;
    int            underflows = 0;

    assign bus.fifo_empty_f     = fifo_empty_q;
    assign bus.fifo_data_output = fifo_dout_q;

    always @(posedge clk) begin
        if (reset_signal) begin
            fifo_mem.delete();
            exp_q.delete();
            last_seen.delete();
            pops    = 0;
            out_cnt = 0;
            max_out = 0;
            fifo_empty_q <= 1'b1;
        end else begin
            if (bus.fifo_read_enable) begin
                if (fifo_mem.size() == 0) underflows++;
                else fifo_dout_q <= fifo_mem.pop_front();
                out_cnt++;
            end
            if (bus.m_valid && bus.m_ready) begin
                pops++;
                out_cnt--;
                if (bus.m_last) last_seen.push_back(bus.m_data);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (wr_en && fifo_mem.size() < 32) begin
                fifo_mem.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            if (out_cnt > max_out) max_out = out_cnt;
            fifo_empty_q <= (fifo_mem.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!reset_signal) begin
            check("no_read_when_empty", 32'(bus.fifo_read_enable & bus.fifo_empty_f), 32'd0);
            check("credit_le_2", 32'(out_cnt <= 2), 32'd1);
            if (bus.m_valid) begin
                check("valid_has_word", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("m_data", bus.m_data, exp_q[0]);
                check("m_last", 32'(bus.m_last), 32'((pops % PL) == PL - 1));
            end else begin
                check("m_last_idle", 32'(bus.m_last), 32'd0);
            end
            check("pkt_count", 32'(bus.pkt_count), 32'((pops / PL) % 65536));
        end
    end

    task automatic do_reset();
        reset_signal = 1'b1;
        wr_en        = 1'b0;
        bus.m_ready  = 1'b0;
        @(posedge clk); #1;
        reset_signal = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_m_data", bus.m_data, 32'd0);
        check("rst_rd_en", 32'(bus.fifo_read_enable), 32'd0);
        check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    endtask

    // Stream 20 words (0..19), optionally stalling the sink for cycles [stall_lo, stall_hi].
    task automatic stream20(input int stall_lo, input int stall_hi, input string tag);
        int cur_run = 0;
        int max_run = 0;
        int n_valid = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            wr_en       = (c < 20);
            wr_data     = 32'(c);
            bus.m_ready = !(c >= stall_lo && c <= stall_hi);
            @(negedge clk);
            if (bus.m_valid) begin
                n_valid++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
        end
        wr_en = 1'b0;
        check({tag, "_delivered"}, 32'(pops), 32'd20);
        check({tag, "_pkt_count"}, 32'(bus.pkt_count), 32'd2);
        check({tag, "_n_last"}, 32'(last_seen.size()), 32'd2);
        if (last_seen.size() == 2) begin
            check({tag, "_last0"}, last_seen[0], 32'd7);
            check({tag, "_last1"}, last_seen[1], 32'd15);
        end
        if (stall_lo > stall_hi) begin
            check({tag, "_valid_run"}, 32'(max_run), 32'd20);
            check({tag, "_valid_cycles"}, 32'(n_valid), 32'd20);
        end else begin
            check({tag, "_max_buffered"}, 32'(max_out), 32'd2);
        end
    endtask

    initial begin
        int nreads, nvalid, rd_cyc, v_cyc, written, budget;
        logic [DW-1:0] v_data;
        logic          v_last;

        bus.m_ready = 1'b0;

        // 1: idle after reset
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.m_ready = 1'b1;
            @(negedge clk);
            check("t1_rd_en", 32'(bus.fifo_read_enable), 32'd0);
            check("t1_m_valid", 32'(bus.m_valid), 32'd0);
        end
        check("t1_pkt_count", 32'(bus.pkt_count), 32'd0);

        // 2: single word, latency read -> valid of two cycles
        do_reset();
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        wr_en       = 1'b1;
        wr_data     = 32'hA5A5_0001;
        @(posedge clk); #1;
        wr_en  = 1'b0;
        nreads = 0; nvalid = 0; rd_cyc = -100; v_cyc = 0; v_data = '0; v_last = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.fifo_read_enable) begin nreads++; rd_cyc = c; end
            if (bus.m_valid) begin
                nvalid++; v_cyc = c; v_data = bus.m_data; v_last = bus.m_last;
            end
            @(posedge clk); #1;
        end
        check("t2_reads", 32'(nreads), 32'd1);
        check("t2_valid_cycles", 32'(nvalid), 32'd1);
        check("t2_latency", 32'(v_cyc - rd_cyc), 32'd2);
        check("t2_data", v_data, 32'hA5A5_0001);
        check("t2_last", 32'(v_last), 32'd0);

        // 3: back-to-back, sink always ready
        do_reset();
        stream20(1, 0, "t3");

        // 4: back-to-back with sink stalled for cycles 3..12
        do_reset();
        stream20(3, 12, "t4");

        // 5: random writes and backpressure, 1000 words
        do_reset();
        written = 0;
        budget  = 0;
        while (pops < 1000 && budget < 20000) begin
            @(posedge clk); #1;
            wr_en       = (written < 1000) && (fifo_mem.size() < 32) && ($urandom_range(0, 1) == 1);
            wr_data     = $urandom;
            if (wr_en) written++;
            bus.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget++;
        end
        wr_en = 1'b0;
        check("t5_delivered", 32'(pops), 32'd1000);
        check("t5_pkt_count", 32'(bus.pkt_count), 32'd125);
        check("t5_leftover", 32'(exp_q.size()), 32'd0);
        check("t5_underflow", 32'(underflows), 32'd0);

        // 6: reset with a read in flight, then a fresh word
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = 32'h100 + 32'(c);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("t6_pre_valid", 32'(bus.m_valid), 32'd1);
        check("t6_pre_inflight", 32'(out_cnt), 32'd2);
        do_reset();
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        wr_en       = 1'b1;
        wr_data     = 32'h1234_5678;
        @(posedge clk); #1;
        wr_en  = 1'b0;
        nvalid = 0; v_data = '0; v_last = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.m_valid) begin nvalid++; v_data = bus.m_data; v_last = bus.m_last; end
            @(posedge clk); #1;
        end
        check("t6_valid_cycles", 32'(nvalid), 32'd1);
        check("t6_data", v_data, 32'h1234_5678);
        check("t6_last", 32'(v_last), 32'd0);
        check("t6_delivered", 32'(pops), 32'd1);
        check("underflow_total", 32'(underflows), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
